// File: rtl/clint_rtc_gen_pkg.sv
// Shared constants for the CLINT RTC reference generator.
// The optional debug-halt input is enabled by defining CLINT_RTC_HALT_EN.
package clint_rtc_gen_pkg;
  localparam int CLINT_RTC_DIV_WIDTH = 16;
  localparam int CLINT_RTC_RST_DIV   = 15;
endpackage

// File: rtl/clint_rtc_shadow.sv
// Valid/ready shadow register for the RTC divider: captures one update
// and holds it pending until the generator releases it with apply_i.
module clint_rtc_shadow #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] div_i,
  input  logic         div_valid_i,
  input  logic         apply_i,
  output logic         div_ready_o,
  output logic         pend_o,
  output logic [W-1:0] div_shd_o
);

  logic         pend_q, pend_d;
  logic [W-1:0] shd_q, shd_d;

  // apply_i only fires while pending, so it never coincides with an acceptance
  always_comb begin
    pend_d = pend_q;
    shd_d  = shd_q;
    if (apply_i) pend_d = 1'b0;
    if (div_valid_i && !pend_q) begin
      pend_d = 1'b1;
      shd_d  = div_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      shd_q  <= '0;
    end else begin
      pend_q <= pend_d;
      shd_q  <= shd_d;
    end
  end

  assign div_ready_o = ~pend_q;
  assign pend_o      = pend_q;
  assign div_shd_o   = shd_q;

endmodule

// File: rtl/clint_rtc_gen.sv
// RTC reference generator for the CLINT: 50%-duty divided clock plus rising-edge tick.
// Define CLINT_RTC_HALT_EN to add the halt_i debug freeze input.
module clint_rtc_gen
  import clint_rtc_gen_pkg::*;
#(
  parameter int                   DIV_WIDTH = CLINT_RTC_DIV_WIDTH,
  parameter logic [DIV_WIDTH-1:0] RST_DIV   = DIV_WIDTH'(CLINT_RTC_RST_DIV)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
`ifdef CLINT_RTC_HALT_EN
  input  logic                 halt_i,
`endif
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 rtc_clk_o,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
  logic                 rtc_q, rtc_d;
  logic                 tick_q, tick_d;
  logic [DIV_WIDTH-1:0] div_shd;
  logic                 pend;
  logic                 apply;
  logic                 run;
  logic                 hold_pend;
  logic                 wrap;

`ifdef CLINT_RTC_HALT_EN
  assign run       = en_i & ~halt_i;
  assign hold_pend = halt_i;
`else
  assign run       = en_i;
  assign hold_pend = 1'b0;
`endif

  assign wrap = (cnt_q == div_act_q);

  clint_rtc_shadow #(.W(DIV_WIDTH)) u_shadow (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .apply_i     (apply),
    .div_ready_o (div_ready_o),
    .pend_o      (pend),
    .div_shd_o   (div_shd)
  );

  // Updates land only on the falling transition so both phases stay whole
  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    rtc_d     = rtc_q;
    tick_d    = 1'b0;
    apply     = 1'b0;
    if (run) begin
      if (wrap) begin
        cnt_d  = '0;
        rtc_d  = ~rtc_q;
        tick_d = ~rtc_q;
        if (pend && rtc_q) begin
          apply     = 1'b1;
          div_act_d = div_shd;
        end
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end else if (pend && !hold_pend) begin
      apply     = 1'b1;
      div_act_d = div_shd;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_act_q <= RST_DIV;
      rtc_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      rtc_q     <= rtc_d;
      tick_q    <= tick_d;
    end
  end

  assign rtc_clk_o = rtc_q;
  assign tick_o    = tick_q;

endmodule
